pio_pulse_arbiter: RTL and testbench

//  Avalon-MM write master that owns one single-bit output PIO (gate/barrier actuator).

---
 rtl/pio_pulse_arbiter_pkg.sv | 21 ++
 rtl/pio_pulse_arbiter_if.sv | 17 +
 rtl/pio_pulse_arbiter_rr_arbiter.sv | 36 +++
 rtl/pio_pulse_arbiter.sv | 123 ++++++++++++
 tb/tb_pio_pulse_arbiter.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/pio_pulse_arbiter_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pio_pulse_arbiter_pkg : FSM state encoding and PIO register constants.
// Revision : 1.0
// -----------------------------------------------------------------------------
package pio_pulse_arbiter_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ASSERT  = 3'd1,
    HOLD    = 3'd2,
    RELEASE = 3'd3,
    GAP     = 3'd4
  } state_t;

  localparam logic [1:0]  PIO_DATA_ADDR = 2'd0;
  localparam logic [31:0] PIO_LEVEL_ON  = 32'd1;
  localparam logic [31:0] PIO_LEVEL_OFF = 32'd0;

endpackage
`default_nettype wire

// File: rtl/pio_pulse_arbiter_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pio_pulse_arbiter_if : Avalon-MM write-only bus towards the single-bit PIO.
// Revision : 1.0
// -----------------------------------------------------------------------------
interface pio_pulse_arbiter_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;

  modport master (output address, chipselect, write_n, writedata);
  modport slave  (input  address, chipselect, write_n, writedata);

endinterface
`default_nettype wire

// File: rtl/pio_pulse_arbiter_rr_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pio_pulse_arbiter_rr_arbiter : combinational round-robin pick starting at rr_ptr.
// Revision : 1.0
// -----------------------------------------------------------------------------
module pio_pulse_arbiter_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    logic found;
    int   j;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // rr_ptr < NUM_REQ, so a single subtraction wraps the search index
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && pending[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pio_pulse_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// pio_pulse_arbiter : shares one PIO output between requesters, one timed pulse per grant.
// Revision : 1.0
// -----------------------------------------------------------------------------
module pio_pulse_arbiter
  import pio_pulse_arbiter_pkg::*;
#(
  parameter int         NUM_REQ  = 2,
  parameter int         HOLD_W   = 24,
  parameter logic [1:0] PIO_ADDR = PIO_DATA_ADDR
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [HOLD_W-1:0]   hold_cycles,
  output logic [NUM_REQ-1:0]  grant,
  output logic                busy,
  output logic                done,
  pio_pulse_arbiter_if.master pio
);

  localparam int IDX_W = $clog2(NUM_REQ);

  state_t              state;
  logic [NUM_REQ-1:0]  req_q;
  logic [NUM_REQ-1:0]  pending;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic [IDX_W-1:0]    rr_ptr;
  logic [IDX_W-1:0]    winner;
  logic [HOLD_W-1:0]   cnt;
  logic [NUM_REQ-1:0]  grant_clr;
  logic                chipselect;
  logic                write_n;
  logic [31:0]         writedata;

  pio_pulse_arbiter_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .pending (pending),
    .rr_ptr  (rr_ptr),
    .gnt     (arb_gnt),
    .idx     (arb_idx)
  );

  assign grant_clr = (state == IDLE && |pending) ? arb_gnt : '0;

  // A new edge on the grant cycle re-arms the request, so the set term is OR-ed last
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q   <= '0;
      pending <= '0;
    end else begin
      req_q   <= req;
      pending <= (pending & ~grant_clr) | (req & ~req_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      writedata  <= PIO_LEVEL_OFF;
      cnt        <= '0;
      rr_ptr     <= '0;
      winner     <= '0;
    end else begin
      chipselect <= 1'b0;
      write_n    <= 1'b1;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (|pending) begin
            grant      <= arb_gnt;
            winner     <= arb_idx;
            cnt        <= (hold_cycles == '0) ? HOLD_W'(1) : hold_cycles;
            busy       <= 1'b1;
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            writedata  <= PIO_LEVEL_ON;
            state      <= ASSERT;
          end
        end
        ASSERT: state <= HOLD;
        HOLD: begin
          // Exit at cnt==1 keeps the state H cycles long and the counter from wrapping
          if (cnt == HOLD_W'(1)) begin
            chipselect <= 1'b1;
            write_n    <= 1'b0;
            writedata  <= PIO_LEVEL_OFF;
            done       <= 1'b1;
            state      <= RELEASE;
          end else begin
            cnt <= cnt - HOLD_W'(1);
          end
        end
        RELEASE: begin
          grant  <= '0;
          rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + IDX_W'(1);
          state  <= GAP;
        end
        GAP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pio.address    = PIO_ADDR;
  assign pio.chipselect = chipselect;
  assign pio.write_n    = write_n;
  assign pio.writedata  = writedata;

endmodule
`default_nettype wire

// File: tb/tb_pio_pulse_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_pio_pulse_arbiter : directed vector table plus hand sequences for pio_pulse_arbiter.
// Revision : 1.0
// -----------------------------------------------------------------------------
module tb_pio_pulse_arbiter;

  logic        clk;
  logic        reset_n;
  logic [1:0]  req;
  logic [23:0] hold_cycles;
  logic [1:0]  grant;
  logic        busy;
  logic        done;

  int n_cmp;
  int n_err;
  int cs_count;

  pio_pulse_arbiter_if pio_bus ();

  pio_pulse_arbiter #(
    .NUM_REQ  (2),
    .HOLD_W   (24),
    .PIO_ADDR (2'd0)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req         (req),
    .hold_cycles (hold_cycles),
    .grant       (grant),
    .busy        (busy),
    .done        (done),
    .pio         (pio_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [23:0] hold;
    logic [1:0]  g1;
    logic [1:0]  g2;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input int h);
    return (h == 0) ? 1 : h;
  endfunction

  always @(negedge clk) begin
    if (reset_n) begin
      chk("wr_n_vs_cs", int'(pio_bus.write_n), int'(!pio_bus.chipselect));
      if (pio_bus.chipselect) begin
        cs_count++;
        chk("pio_address", int'(pio_bus.address), 0);
      end
    end
  end

  task automatic wait_write(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 0; i < 64 && !seen; i++) begin
      tick();
      cyc++;
      if (pio_bus.chipselect === 1'b1) seen = 1'b1;
    end
    chk("write_timeout", int'(seen), 1);
  endtask

  // One full pulse: ASSERT write, ignored mid-pulse hold change, RELEASE write, GAP, IDLE
  task automatic check_pulse(input logic [1:0] exp_g, input int exp_lat, input int h);
    int          cyc;
    logic [23:0] saved;
    wait_write(cyc);
    chk("assert_latency", cyc, exp_lat);
    chk("assert_data", int'(pio_bus.writedata), 1);
    chk("assert_grant", int'(grant), int'(exp_g));
    chk("assert_busy", int'(busy), 1);
    saved       = hold_cycles;
    hold_cycles = hold_cycles + 24'd3;
    req         = 2'b00;
    wait_write(cyc);
    chk("hold_length", cyc, eff(h) + 1);
    chk("release_data", int'(pio_bus.writedata), 0);
    chk("release_done", int'(done), 1);
    chk("release_grant", int'(grant), int'(exp_g));
    tick();
    chk("gap_grant", int'(grant), 0);
    chk("gap_busy", int'(busy), 1);
    chk("gap_done", int'(done), 0);
    hold_cycles = saved;
    tick();
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    int cyc;
    n_cmp       = 0;
    n_err       = 0;
    cs_count    = 0;
    reset_n     = 1'b0;
    req         = 2'b00;
    hold_cycles = 24'd0;

    vecs[0] = '{req: 2'b11, hold: 24'd2, g1: 2'b01, g2: 2'b10};
    vecs[1] = '{req: 2'b11, hold: 24'd4, g1: 2'b01, g2: 2'b10};
    vecs[2] = '{req: 2'b01, hold: 24'd5, g1: 2'b01, g2: 2'b00};
    vecs[3] = '{req: 2'b11, hold: 24'd3, g1: 2'b10, g2: 2'b01};
    vecs[4] = '{req: 2'b01, hold: 24'd0, g1: 2'b01, g2: 2'b00};
    vecs[5] = '{req: 2'b10, hold: 24'd1, g1: 2'b10, g2: 2'b00};
    vecs[6] = '{req: 2'b10, hold: 24'd6, g1: 2'b10, g2: 2'b00};

    repeat (2) tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_cs", int'(pio_bus.chipselect), 0);
    chk("rst_wr_n", int'(pio_bus.write_n), 1);
    chk("rst_wdata", int'(pio_bus.writedata), 0);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_wr_n", int'(pio_bus.write_n), 1);
      chk("idle_cs", int'(pio_bus.chipselect), 0);
      chk("idle_busy0", int'(busy), 0);
    end

    for (int v = 0; v < 7; v++) begin
      cs_count    = 0;
      hold_cycles = vecs[v].hold;
      req         = vecs[v].req;
      check_pulse(vecs[v].g1, 2, int'(vecs[v].hold));
      if (vecs[v].g2 != 2'b00) check_pulse(vecs[v].g2, 1, int'(vecs[v].hold));
      repeat (4) tick();
      chk("cs_pulse_count", cs_count, (vecs[v].g2 != 2'b00) ? 4 : 2);
    end

    // Two extra req[1] edges during its own HOLD collapse into one further pulse
    cs_count    = 0;
    hold_cycles = 24'd6;
    req         = 2'b10;
    wait_write(cyc);
    chk("rereq_grant", int'(grant), 2);
    req = 2'b00; tick();
    req = 2'b10; tick();
    req = 2'b00; tick();
    req = 2'b10; tick();
    req = 2'b00;
    wait_write(cyc);
    chk("rereq_release", int'(pio_bus.writedata), 0);
    chk("rereq_done", int'(done), 1);
    wait_write(cyc);
    chk("rereq_gap_to_assert", cyc, 3);
    chk("rereq_second_grant", int'(grant), 2);
    chk("rereq_second_data", int'(pio_bus.writedata), 1);
    wait_write(cyc);
    chk("rereq_second_len", cyc, 7);
    repeat (20) tick();
    chk("rereq_cs_count", cs_count, 4);

    // Asynchronous reset in the middle of HOLD
    hold_cycles = 24'd10;
    req         = 2'b01;
    wait_write(cyc);
    chk("midrst_assert", int'(grant), 1);
    req = 2'b00;
    repeat (3) tick();
    chk("midrst_busy_before", int'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_cs", int'(pio_bus.chipselect), 0);
    chk("midrst_wr_n", int'(pio_bus.write_n), 1);
    chk("midrst_wdata", int'(pio_bus.writedata), 0);
    repeat (2) tick();
    reset_n     = 1'b1;
    tick();
    cs_count    = 0;
    hold_cycles = 24'd2;
    req         = 2'b10;
    check_pulse(2'b10, 2, 2);
    repeat (4) tick();
    chk("postrst_cs_count", cs_count, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
